// File: rtl/ex3_pkg.sv
// ex3_pkg: shared FSM states and excess-3 code constants for the excess-3 decode path.
package ex3_pkg;
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   localparam int DIG_W = 4;
   localparam logic [3:0] EX3_OFFSET = 4'd3;
   localparam logic [3:0] EX3_MIN = 4'b0011;
   localparam logic [3:0] EX3_MAX = 4'b1100;
endpackage

// File: rtl/ex3_digit_dec.sv
// ex3_digit_dec: combinational single-digit excess-3 to BCD decoder; illegal codes give 0 with err set.
module ex3_digit_dec
   import ex3_pkg::*;
(
   input  logic [3:0] code,
   output logic [3:0] dig,
   output logic       err
);
   assign err = (code < EX3_MIN) || (code > EX3_MAX);
   assign dig = err ? 4'd0 : code - EX3_OFFSET;
endmodule

// File: rtl/ex3_to_bcd_stream.sv
// ex3_to_bcd_stream: stream decoder of NDIG excess-3 digits to BCD, one digit per clock, MSB first.
// Define EX3DEC_BINARY_EN to add the out_bin binary accumulator output.
module ex3_to_bcd_stream
   import ex3_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*NDIG-1:0]     in_ex3,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*NDIG-1:0]     out_bcd,
   output logic [NDIG-1:0]       out_err,
`ifdef EX3DEC_BINARY_EN
   output logic [4*NDIG-1:0]     out_bin,
`endif
   output logic                  out_any_err
);
   localparam int W = DIG_W * NDIG;
   localparam int CW = $clog2(NDIG) + 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
   state_t state, nxt;
   logic [W-1:0] sr, bcd;
   logic [W+3:0] bcd_sh;
   logic [NDIG-1:0] err;
   logic [NDIG:0] err_sh;
   logic [CW-1:0] cnt;
   logic [3:0] dig;
   logic derr, accept;
   ex3_digit_dec u_dec (.code(sr[W-1 -: 4]), .dig(dig), .err(derr));
   assign accept = in_valid && in_ready;
   assign bcd_sh = {bcd, dig};
   assign err_sh = {err, derr};
   always_comb begin
      nxt = state;
      case (state)
         IDLE: nxt = accept ? CONV : IDLE;
         CONV: nxt = (cnt == LAST) ? DONE : CONV;
         DONE: nxt = out_ready ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
   end
   // in_ready is registered, so it only rises on the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         in_ready <= 1'b0;
      end else begin
         state <= nxt;
         in_ready <= (nxt == IDLE);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
         bcd <= '0;
         err <= '0;
         cnt <= '0;
      end else if (state == IDLE && accept) begin
         sr <= in_ex3;
         bcd <= '0;
         err <= '0;
         cnt <= '0;
      end else if (state == CONV) begin
         sr <= sr << DIG_W;
         bcd <= bcd_sh[W-1:0];
         err <= err_sh[NDIG-1:0];
         cnt <= cnt + CW'(1);
      end
   end
`ifdef EX3DEC_BINARY_EN
   logic [W-1:0] bin;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bin <= '0;
      else if (state == IDLE && accept) bin <= '0;
      else if (state == CONV) bin <= (bin << 3) + (bin << 1) + W'(dig);
   end
   assign out_bin = bin;
`endif
   assign out_valid = (state == DONE);
   assign out_bcd = bcd;
   assign out_err = err;
   assign out_any_err = |err;
endmodule

// File: tb/tb_ex3_to_bcd_stream.sv
// tb_ex3_to_bcd_stream: directed self-checking bench for ex3_to_bcd_stream with NDIG=4.
// Binary output checks are active when EX3DEC_BINARY_EN is defined.
module tb_ex3_to_bcd_stream;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [15:0] in_ex3 = 16'h0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [15:0] out_bcd;
   logic [3:0] out_err;
   logic out_any_err;
`ifdef EX3DEC_BINARY_EN
   logic [15:0] out_bin;
`endif
   int total = 0;
   int bad = 0;

   ex3_to_bcd_stream #(.NDIG(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_ex3(in_ex3),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_bcd(out_bcd),
      .out_err(out_err),
`ifdef EX3DEC_BINARY_EN
      .out_bin(out_bin),
`endif
      .out_any_err(out_any_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one word through; lat counts edges after the accept edge until out_valid (4 = T+5).
   task automatic run_word(input logic [15:0] w, input bit hold, output logic [15:0] bcd,
                           output logic [3:0] err, output logic any, output logic [15:0] bin,
                           output int lat);
      int n = 0;
      while (!in_ready && n < 30) begin
         tick();
         n++;
      end
      in_valid = 1'b1;
      in_ex3 = w;
      tick();
      in_valid = 1'b0;
      in_ex3 = 16'hFFFF;
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      bcd = out_bcd;
      err = out_err;
      any = out_any_err;
`ifdef EX3DEC_BINARY_EN
      bin = out_bin;
`else
      bin = 16'h0;
`endif
      if (!hold) begin
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (out_valid !== 1'b0 || out_bcd !== 16'h0 || out_err !== 4'h0 || out_any_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%b bcd=%h err=%b any=%b, need 0/0000/0000/0",
                  out_valid, out_bcd, out_err, out_any_err);
      end
`ifdef EX3DEC_BINARY_EN
      total++;
      if (out_bin !== 16'h0) begin
         bad++;
         $display("FAIL reset_bin: got %h need 0000", out_bin);
      end
`endif
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %b need 1", in_ready);
      end
   endtask

   task automatic test_word(input string name, input logic [15:0] w, input logic [15:0] ebcd,
                            input logic [3:0] eerr, input logic [15:0] ebin);
      logic [15:0] bcd, bin;
      logic [3:0] err;
      logic any;
      int lat;
      run_word(w, 1'b0, bcd, err, any, bin, lat);
      total++;
      if (bcd !== ebcd || err !== eerr || any !== (eerr != 4'h0)) begin
         bad++;
         $display("FAIL %s: got bcd=%h err=%b any=%b, need bcd=%h err=%b any=%b",
                  name, bcd, err, any, ebcd, eerr, eerr != 4'h0);
      end
      total++;
      if (lat != 4) begin
         bad++;
         $display("FAIL %s_latency: got %0d edges after accept, need 4", name, lat);
      end
`ifdef EX3DEC_BINARY_EN
      total++;
      if (bin !== ebin) begin
         bad++;
         $display("FAIL %s_bin: got %h need %h", name, bin, ebin);
      end
`endif
   endtask

   task automatic test_backpressure();
      logic [15:0] bcd, bin;
      logic [3:0] err;
      logic any;
      int lat;
      run_word(16'h3C3C, 1'b1, bcd, err, any, bin, lat);
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== 16'h0909 || out_err !== 4'h0) begin
            bad++;
            $display("FAIL backpressure_hold%0d: got valid=%b ready=%b bcd=%h err=%b, need 1/0/0909/0000",
                     i, out_valid, in_ready, out_bcd, out_err);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL backpressure_release: got valid=%b ready=%b need 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w [3] = '{16'h4567, 16'hCCCC, 16'h3333};
      logic [15:0] e [3] = '{16'h1234, 16'h9999, 16'h0000};
      logic [15:0] got [3];
      int tm [3];
      int idx = 0;
      int nres = 0;
      bit acc;
      in_ex3 = w[0];
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 60 && nres < 3; c++) begin
         acc = in_ready && in_valid;
         if (out_valid) begin
            got[nres] = out_bcd;
            tm[nres] = c;
            nres++;
         end
         tick();
         if (acc) begin
            idx++;
            if (idx < 3) in_ex3 = w[idx];
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      total++;
      if (nres != 3) begin
         bad++;
         $display("FAIL b2b_count: got %0d results need 3", nres);
      end else begin
         for (int k = 0; k < 3; k++) begin
            total++;
            if (got[k] !== e[k]) begin
               bad++;
               $display("FAIL b2b_word%0d: got %h need %h", k, got[k], e[k]);
            end
         end
         for (int k = 1; k < 3; k++) begin
            total++;
            if (tm[k] - tm[k-1] != 6) begin
               bad++;
               $display("FAIL b2b_spacing%0d: got %0d cycles need 6", k, tm[k] - tm[k-1]);
            end
         end
      end
      tick();
   endtask

   task automatic test_reset_mid_conv();
      int n = 0;
      while (!in_ready && n < 30) begin
         tick();
         n++;
      end
      in_valid = 1'b1;
      in_ex3 = 16'hCCCC;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_bcd !== 16'h0 || out_err !== 4'h0 || out_any_err !== 1'b0) begin
         bad++;
         $display("FAIL midconv_reset: got valid=%b bcd=%h err=%b any=%b need 0/0000/0000/0",
                  out_valid, out_bcd, out_err, out_any_err);
      end
`ifdef EX3DEC_BINARY_EN
      total++;
      if (out_bin !== 16'h0) begin
         bad++;
         $display("FAIL midconv_reset_bin: got %h need 0000", out_bin);
      end
`endif
      tick();
      rst_n = 1'b1;
      tick();
      test_word("after_reset", 16'h4567, 16'h1234, 4'b0000, 16'h04D2);
   endtask

   initial begin
      test_reset();
      test_word("legal", 16'h4567, 16'h1234, 4'b0000, 16'h04D2);
      test_word("all_zero", 16'h3333, 16'h0000, 4'b0000, 16'h0000);
      test_word("all_nine", 16'hCCCC, 16'h9999, 4'b0000, 16'h270F);
      test_word("mixed_ext", 16'h3C3C, 16'h0909, 4'b0000, 16'h038D);
      test_word("illegal_one", 16'h4F56, 16'h1023, 4'b0100, 16'h03FF);
      test_word("illegal_all", 16'h0000, 16'h0000, 4'b1111, 16'h0000);
      test_backpressure();
      test_back_to_back();
      test_reset_mid_conv();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ex3_to_bcd_stream.md
# ex3_to_bcd_stream

Multi-digit excess-3 to BCD decoder with a valid/ready stream interface on both sides. It is the receive-side counterpart of the team's BCD-to-excess-3 encoding path. A packed word of NDIG excess-3 digits is accepted, decoded one digit per clock (MSB digit first), and presented as a packed BCD word with per-digit error flags. It sits between the excess-3 link/capture logic and downstream BCD display and arithmetic blocks.

## Interface
- NDIG, 4, number of 4-bit digits per word (1..8)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_ex3  in  4*NDIG  packed excess-3 digits; digit i = bits [4i+3:4i]; digit NDIG-1 is most significant
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_bcd  out  4*NDIG  packed BCD digits, same ordering as in_ex3
- out_err  out  NDIG  bit i set when input digit i was not a legal excess-3 code
- out_any_err  out  1  OR of out_err
- out_bin  out  4*NDIG  binary value of out_bcd; present only with EX3DEC_BINARY_EN

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_ex3 into the shift register, clear the digit counter, the error register and the accumulator, and go to CONV.
- CONV: in_ready=0. Each cycle, decode the current MSB digit of the shift register, shift it into the BCD result, set its out_err bit, and increment the counter. After NDIG digits, go to DONE.
- DONE: out_valid=1. Outputs stay stable until out_ready=1. On out_valid&&out_ready, go to IDLE.
- Digit decode: legal codes 4'b0011..4'b1100 map to code-3, giving 0..9. Illegal codes (0000, 0001, 0010, 1101, 1110, 1111) decode to digit 4'b0000 with the error bit set. No X is ever driven.
- An error digit does not abort the word; conversion always completes all NDIG digits.
- Counter width is clog2(NDIG)+1. The counter never wraps within a word.
- Reset, asserted at any time including mid-CONV or in DONE, immediately aborts the word.
- Reset values: state=IDLE, in_ready=1 (after the first clock edge with rst_n high), out_valid=0, out_bcd=0, out_err=0, out_any_err=0, out_bin=0.

## Timing
- Accept handshake in cycle T. Digits are decoded in cycles T+1..T+NDIG. out_valid goes high in cycle T+NDIG+1.
- in_ready is registered. It is low from T+1 until the cycle after the output handshake.
- Minimum word period is NDIG+2 cycles when out_ready is held high.
- in_ready is 0 whenever out_valid is 1. A new input handshake is never accepted in the same cycle as an output handshake.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE, and in_ex3 may change freely while the block is busy.

## Configuration
- EX3DEC_BINARY_EN defined: an accumulator computes bin = bin*10 + digit during each CONV cycle (an error digit contributes 0). out_bin is valid alongside out_valid. The multiply by 10 is implemented as (bin<<3)+(bin<<1), 4*NDIG bits wide; 10^NDIG-1 always fits, so no overflow is possible.
- EX3DEC_BINARY_EN undefined: the out_bin port, the accumulator and the multiply logic are absent. All other behaviour and timing are identical.

## Structure
- Shared package ex3_pkg: the FSM state enum (IDLE, CONV, DONE), the constants EX3_OFFSET=4'd3, EX3_MIN=4'b0011 and EX3_MAX=4'b1100, and a digit width constant of 4.
- Sub-module ex3_digit_dec: combinational single-digit decoder (4-bit code in, 4-bit digit out, 1-bit err out). It is instantiated once, on the shift-register MSB digit.

## Test plan
All scenarios use NDIG=4.
- Legal word: in_ex3=16'h4567 -> out_bcd=16'h1234, out_err=4'b0000, out_bin=16'h04D2; out_valid rises exactly 5 cycles after the accept cycle.
- Extremes: 16'h3333 -> out_bcd=16'h0000, out_bin=0. 16'hCCCC -> out_bcd=16'h9999, out_bin=16'h270F. 16'h3C3C -> out_bcd=16'h0909, out_bin=16'h038D.
- Illegal digit: 16'h4F56 -> out_bcd=16'h1023, out_err=4'b0100, out_any_err=1, out_bin=16'h03FF. Separately, 16'h0000 -> out_err=4'b1111, out_bcd=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and all outputs stay stable and in_ready stays 0. A later out_ready pulse completes the handshake, and in_ready=1 on the next cycle.
- Back-to-back: in_valid and out_ready held high with three words -> results appear in order, spaced 6 cycles apart.
- Reset mid-CONV: assert rst_n=0 two cycles after accept -> out_valid=0 and all outputs zero immediately. After release, the next word 16'h4567 decodes correctly with no residue from the aborted word.
